// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// The lookup is combinational and feeds the IF-stage PC-select mux directly.
// Training comes from EX with the resolved outcome. Mispredictions are flagged
// and counted.
module branch_predictor #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PC_WIDTH-1:0]  if_pc,
    output logic                 pred_taken,
    output logic [PC_WIDTH-1:0]  pred_target,
    input  logic                 upd_valid,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic                 upd_taken,
    input  logic [PC_WIDTH-1:0]  upd_target,
    input  logic                 upd_pred_taken,
    input  logic [PC_WIDTH-1:0]  upd_pred_target,
    output logic                 mispredict,
    output logic [CNT_WIDTH-1:0] mispredict_cnt
);

    localparam int unsigned Entries = 1 << INDEX_BITS;
    localparam int unsigned TagW    = PC_WIDTH - INDEX_BITS - 2;

    logic                valid_q  [Entries];
    logic [TagW-1:0]     tag_q    [Entries];
    logic [PC_WIDTH-1:0] target_q [Entries];
    logic [1:0]          ctr_q    [Entries];

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [INDEX_BITS-1:0] if_idx, upd_idx;
    logic [TagW-1:0]       if_tag, upd_tag;
    logic                  if_hit, upd_hit;

    // Byte-offset bits never take part in indexing or tag matching.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

    assign if_idx  = if_pc[INDEX_BITS+1:2];
    assign if_tag  = if_pc[PC_WIDTH-1:INDEX_BITS+2];
    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_tag = upd_pc[PC_WIDTH-1:INDEX_BITS+2];

    // Zero-latency lookup; always sees the pre-update entry (no bypass).
    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = if_hit && ctr_q[if_idx][1];
        pred_target = if_hit ? target_q[if_idx] : '0;
    end

    // Direction miss, or both taken but to different targets.
    always_comb begin
        mispredict = upd_valid &&
                     ((upd_pred_taken != upd_taken) ||
                      (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));
    end

    // Next-state of the entry addressed by the update port.
    logic                ent_we;
    logic                ent_valid_d;
    logic [TagW-1:0]     ent_tag_d;
    logic [PC_WIDTH-1:0] ent_target_d;
    logic [1:0]          ent_ctr_d;

    always_comb begin
        upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        ent_we       = 1'b0;
        ent_valid_d  = valid_q[upd_idx];
        ent_tag_d    = tag_q[upd_idx];
        ent_target_d = target_q[upd_idx];
        ent_ctr_d    = ctr_q[upd_idx];
        if (upd_valid) begin
            if (upd_hit) begin
                ent_we = 1'b1;
                if (upd_taken) begin
                    ent_ctr_d    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                    ent_target_d = upd_target;
                end else begin
                    ent_ctr_d = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocate, or replace an aliasing entry, as weakly taken.
                ent_we       = 1'b1;
                ent_valid_d  = 1'b1;
                ent_tag_d    = upd_tag;
                ent_target_d = upd_target;
                ent_ctr_d    = 2'b10;
            end
        end
    end

    // Entry storage: synchronous reset clears everything, else write the trained entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (ent_we) begin
            valid_q[upd_idx]  <= ent_valid_d;
            tag_q[upd_idx]    <= ent_tag_d;
            target_q[upd_idx] <= ent_target_d;
            ctr_q[upd_idx]    <= ent_ctr_d;
        end
    end

    // Saturating mispredict counter next-state.
    always_comb begin
        cnt_d = cnt_q;
        if (mispredict && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Mispredict counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor plus hand sequences for
// reset-over-update and counter saturation on a narrow-counter instance.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        pred_taken,  pred_taken4;
    logic [31:0] pred_target, pred_target4;
    logic        mispredict,  mispredict4;
    logic [15:0] mispredict_cnt;
    logic [3:0]  mispredict_cnt4;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .mispredict_cnt  (mispredict_cnt)
    );

    branch_predictor #(
        .CNT_WIDTH (4)
    ) u_dut4 (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken4),
        .pred_target     (pred_target4),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict4),
        .mispredict_cnt  (mispredict_cnt4)
    );

    typedef struct {
        logic [31:0] if_pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        e_pt;
        logic [31:0] e_tgt;
        logic        e_mp;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] ipc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic upt,
                       input logic [31:0] uptgt, input logic e_pt, input logic [31:0] e_tgt,
                       input logic e_mp, input logic [15:0] e_cnt);
        vec_t v;
        v.if_pc = ipc;  v.uv = uv;     v.upc = upc;     v.ut = ut;   v.utgt = utgt;
        v.upt = upt;    v.uptgt = uptgt; v.e_pt = e_pt; v.e_tgt = e_tgt;
        v.e_mp = e_mp;  v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ipc, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt, input logic upt,
                         input logic [31:0] uptgt);
        if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   if_pc   uv upd_pc  t  target  pt  ptgt    | e_pt e_tgt  e_mp e_cnt
        // Test 1: lookup after reset
        add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 0);
        // Test 2: first taken update allocates, mispredicts
        add(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,    0, 32'h0,   1, 0);
        add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,    1, 32'h200, 0, 1);
        // Test 3: counter walk 10->01->00->01->10->11->11->10
        add(32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h200,  1, 32'h200, 1, 1);
        add(32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h0,    0, 32'h200, 0, 2);
        add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,    0, 32'h200, 0, 2);
        add(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,    0, 32'h200, 1, 2);
        add(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,    0, 32'h200, 1, 3);
        add(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200,  1, 32'h200, 0, 4);
        add(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200,  1, 32'h200, 0, 4);
        add(32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h200,  1, 32'h200, 1, 4);
        add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,    1, 32'h200, 0, 5);
        // Test 4: alias 0x140 replaces 0x100 at index 0; not-taken miss leaves it
        add(32'h140, 1, 32'h140, 1, 32'h300, 0, 32'h0,    0, 32'h0,   1, 5);
        add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 6);
        add(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,    1, 32'h300, 0, 6);
        add(32'h140, 1, 32'h180, 0, 32'h0,   0, 32'h0,    1, 32'h300, 0, 6);
        add(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,    1, 32'h300, 0, 6);
        add(32'h180, 0, 32'h0,   0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 6);
        // Test 5: same-cycle lookup sees pre-update entry; target-only mispredict
        add(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,    0, 32'h0,   1, 6);
        add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,    1, 32'h200, 0, 7);
        add(32'h100, 1, 32'h100, 1, 32'h204, 1, 32'h200,  1, 32'h200, 1, 7);
        add(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,    1, 32'h204, 0, 8);
        // Second index, correct prediction, low PC bits ignored
        add(32'h104, 1, 32'h104, 1, 32'h400, 1, 32'h400,  0, 32'h0,   0, 8);
        add(32'h107, 0, 32'h0,   0, 32'h0,   0, 32'h0,    1, 32'h400, 0, 8);
        // upd_valid=0: no mispredict even with disagreeing fields, no training
        add(32'h100, 0, 32'h100, 0, 32'h0,   1, 32'h200,  1, 32'h204, 0, 8);
        add(32'h104, 0, 32'h0,   0, 32'h0,   0, 32'h0,    1, 32'h400, 0, 8);

        rst_n = 1'b0;
        drive(32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.if_pc, v.uv, v.upc, v.ut, v.utgt, v.upt, v.uptgt);
            #3;
            check($sformatf("v%0d pred_taken", i), {31'b0, pred_taken}, {31'b0, v.e_pt});
            check($sformatf("v%0d pred_target", i), pred_target, v.e_tgt);
            check($sformatf("v%0d mispredict", i), {31'b0, mispredict}, {31'b0, v.e_mp});
            check($sformatf("v%0d cnt", i), {16'b0, mispredict_cnt}, {16'b0, v.e_cnt});
            next_cycle();
        end

        // Reset together with an allocating, mispredicting update: reset wins.
        rst_n = 1'b0;
        drive(32'h100, 1, 32'h100, 1, 32'h500, 0, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        drive(32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #3;
        check("rst pred_taken 0x100", {31'b0, pred_taken}, 32'h0);
        check("rst pred_target 0x100", pred_target, 32'h0);
        check("rst cnt", {16'b0, mispredict_cnt}, 32'h0);
        check("rst cnt4", {28'b0, mispredict_cnt4}, 32'h0);
        if_pc = 32'h104;
        #1;
        check("rst pred_taken 0x104", {31'b0, pred_taken}, 32'h0);
        next_cycle();

        // Counter saturation: direction mispredicts on a not-taken miss (no allocation).
        drive(32'h0, 1, 32'h8, 0, 32'h0, 1, 32'h0);
        for (int k = 0; k < 16; k++) next_cycle();
        drive(32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #3;
        check("sat cnt4 after 16", {28'b0, mispredict_cnt4}, 32'hF);
        check("cnt16 after 16", {16'b0, mispredict_cnt}, 32'd16);
        next_cycle();
        drive(32'h0, 1, 32'h8, 0, 32'h0, 1, 32'h0);
        next_cycle();
        drive(32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #3;
        check("sat cnt4 holds", {28'b0, mispredict_cnt4}, 32'hF);
        check("cnt16 after 17", {16'b0, mispredict_cnt}, 32'd17);
        check("not-taken miss no alloc", {31'b0, pred_taken}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
